// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: a two-entry skid buffer between fetch and decode,
// with flush, MIPS field decode of the held word and a saturating stall counter.
module if_id_stage #(
    parameter logic [31:0] BUBBLE = 32'h00000000,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ir,
    input  logic [31:0]      npc,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      id_ir,
    output logic [31:0]      id_npc,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [15:0]      imm,
    output logic [25:0]      jtarget,
    output logic [31:0]      imm_se,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic        main_valid, main_valid_n;
    logic        skid_valid, skid_valid_n;
    logic [31:0] main_ir, main_ir_n, main_npc, main_npc_n;
    logic [31:0] skid_ir, skid_ir_n, skid_npc, skid_npc_n;
    logic [CNT_W-1:0] stall_cnt_n;
    logic        accept, out_evt;

    assign accept  = in_valid && in_ready;
    assign out_evt = main_valid && out_ready;

    // Next-state for both entries: refill main from skid first, else from fetch.
    always_comb begin
        main_valid_n = main_valid;
        skid_valid_n = skid_valid;
        main_ir_n    = main_ir;
        main_npc_n   = main_npc;
        skid_ir_n    = skid_ir;
        skid_npc_n   = skid_npc;
        stall_cnt_n  = stall_cnt;

        if (main_valid && !out_ready && stall_cnt != CNT_MAX)
            stall_cnt_n = stall_cnt + CNT_W'(1);

        if (flush) begin
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else if (out_evt && skid_valid) begin
            main_valid_n = 1'b1;
            main_ir_n    = skid_ir;
            main_npc_n   = skid_npc;
            skid_valid_n = 1'b0;
        end else if (accept && (!main_valid || out_evt)) begin
            main_valid_n = 1'b1;
            main_ir_n    = ir;
            main_npc_n   = npc;
        end else if (accept) begin
            skid_valid_n = 1'b1;
            skid_ir_n    = ir;
            skid_npc_n   = npc;
        end else if (out_evt) begin
            main_valid_n = 1'b0;
        end
    end

    // State registers; in_ready is registered from the next skid occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            main_ir    <= BUBBLE;
            main_npc   <= 32'h0;
            skid_ir    <= BUBBLE;
            skid_npc   <= 32'h0;
            stall_cnt  <= '0;
        end else begin
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
            in_ready   <= !skid_valid_n;
            main_ir    <= main_ir_n;
            main_npc   <= main_npc_n;
            skid_ir    <= skid_ir_n;
            skid_npc   <= skid_npc_n;
            stall_cnt  <= stall_cnt_n;
        end
    end

    // Presented beat, forced to a bubble while main is empty.
    always_comb begin
        out_valid = main_valid;
        id_ir     = main_valid ? main_ir  : BUBBLE;
        id_npc    = main_valid ? main_npc : 32'h0;
    end

    assign opcode  = id_ir[31:26];
    assign rs      = id_ir[25:21];
    assign rt      = id_ir[20:16];
    assign rd      = id_ir[15:11];
    assign shamt   = id_ir[10:6];
    assign funct   = id_ir[5:0];
    assign imm     = id_ir[15:0];
    assign jtarget = id_ir[25:0];
    assign imm_se  = {{16{id_ir[15]}}, id_ir[15:0]};

endmodule
